// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage sitting directly behind the pc counter.
// It issues one instruction-memory read per accepted address and keeps at most
// one request outstanding. Returned words are buffered with their PCs in a
// DEPTH-entry FIFO that feeds decode.
// A redirect flushes the buffer. A response that was in flight at the redirect
// is dropped.
// Optional build macro FETCH_TIMEOUT_EN adds a response timeout and the sticky
// fetch_err flag. Without it, fetch_err is tied to 0.
//
// Handshake (decode side): the head entry transfers on a rising clk edge where
// if_valid && id_ready. While if_valid=1 and id_ready=0 the head (if_pc,
// if_instr) holds stable. Memory side: imem_req is a one-cycle strobe. The
// response arrives as a single imem_rvalid cycle at least one cycle later.
// dbg_state exposes the FSM encoding: 0=IDLE, 1=WAIT, 2=DROP.
module fetch_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_count,
   output logic              pc_advance,
   input  logic              redirect,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready,
   output logic              fetch_err,
   output logic [1:0]        dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_saved_q, pc_saved_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic issue;    // request accepted this cycle
   logic push;     // response written into the FIFO tail
   logic pop;      // head taken by decode
   logic timeout;  // outstanding response given up on

   // FSM next state: issue from IDLE when a slot is free; WAIT and DROP consume the response
   always_comb begin
      state_d    = state_q;
      pc_saved_d = pc_saved_q;
      issue      = 1'b0;
      push       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A slot is reserved at issue time, so a later push always finds room.
            if (!reset && !redirect && (count_q < FULL)) begin
               issue      = 1'b1;
               pc_saved_d = pc_count;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               // A redirect in the same cycle discards the response.
               push    = !redirect;
               state_d = S_IDLE;
            end else if (timeout) begin
               state_d = S_IDLE;
            end else if (redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            // The response belongs to the flushed path; swallow it.
            if (imem_rvalid || timeout) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO pointers and count; redirect clears everything and overrides push/pop
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State, saved PC, pointers and count registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_saved_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_saved_q <= pc_saved_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage: write {pc, instr} at the tail on push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= pc_saved_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             err_q, err_d;

   // Give up when the TIMEOUT-th cycle spent in WAIT/DROP also has no response
   assign timeout = (state_q != S_IDLE) && !imem_rvalid &&
                    (tmr_q == TMR_W'(TIMEOUT - 1));

   // Timer restarts on every entry to WAIT or DROP; error is sticky
   always_comb begin
      tmr_d = '0;
      err_d = err_q | timeout;
      if ((state_q != S_IDLE) && (state_d == state_q)) begin
         tmr_d = tmr_q + TMR_W'(1);
      end
   end

   // Timer and error flag registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmr_q <= tmr_d;
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   assign pop        = (count_q != '0) && id_ready && !redirect;
   assign imem_req   = issue;
   assign pc_advance = issue;
   assign imem_addr  = issue ? pc_count : '0;
   assign if_valid   = (count_q != '0);
   assign if_instr   = if_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign dbg_state  = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly downstream of the pc counter.
- Takes the current 32-bit count from pc and issues one instruction-memory read per accepted address.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports flush on redirect (branch/jump) and discards in-flight responses.

Parameters:
ADDR_W, 32, width of PC / instruction-memory address
DATA_W, 32, instruction width
DEPTH, 2, fetch buffer entries (power of two, >=2)
TIMEOUT, 16, max WAIT cycles before error (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
pc_count  input  ADDR_W  current address from pc
pc_advance  output  1  pc increments count by 4 on the clock edge where this is 1
redirect  input  1  flush request from execute; one-cycle pulse
imem_req  output  1  read request, single cycle
imem_addr  output  ADDR_W  read address, valid when imem_req=1
imem_rvalid  input  1  read data valid, >=1 cycle after imem_req
imem_rdata  input  DATA_W  instruction word
if_valid  output  1  buffer head valid
if_instr  output  DATA_W  head instruction
if_pc  output  ADDR_W  head PC
id_ready  input  1  decode accepts head
fetch_err  output  1  sticky timeout flag (0 without macro)

Behaviour:
- Reset (async, any state): state=IDLE, FIFO count=0, rd/wr pointers=0, pc_advance=0, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.
- At most one outstanding memory request.
- FSM states IDLE, WAIT, DROP:
  - IDLE: if !redirect and count<DEPTH -> imem_req=1, imem_addr=pc_count, pc_advance=1 (combinational, same cycle); latch pc_count into pc_saved; go WAIT.
  - IDLE with count==DEPTH or redirect=1: no request; stay IDLE.
  - WAIT: on imem_rvalid, push {pc_saved, imem_rdata} to FIFO tail; go IDLE. The next request can issue in the following cycle, so peak rate is 1 fetch per 2 cycles.
  - WAIT + redirect, no imem_rvalid same cycle: go DROP.
  - WAIT + redirect and imem_rvalid same cycle: response discarded; go IDLE.
  - DROP: imem_rvalid discarded; go IDLE. No request issued while in DROP.
- Slot reservation: a request issues only when count<DEPTH. Pops never reduce count below 0, and a push is always guaranteed space, so there is no overflow.
- Decode interface:
  - if_valid = (count!=0); if_instr/if_pc driven from the head entry, 0 when empty.
  - Pop on if_valid && id_ready.
  - Head must hold stable while if_valid=1 and id_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance; the pushed entry becomes visible per FIFO order.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Redirect (highest priority):
  - Same edge: count=0, pointers=0, any pop/push that cycle ignored.
  - if_valid=0 from the next cycle.
  - The PC module loads its new target externally; fetch resumes from pc_count in IDLE the cycle after redirect.
- imem_rvalid in IDLE is ignored (protocol error, no state change).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to WAIT/DROP and increments each cycle there.
  - When it reaches TIMEOUT without imem_rvalid, fetch_err is set (sticky until reset), the FSM returns to IDLE, and the lost instruction is not pushed.
  - A late imem_rvalid arriving in IDLE is ignored.
- Not defined: no counter; WAIT/DROP wait indefinitely; fetch_err tied to 0.

Test Plan:
- Reset: assert reset mid-WAIT with buffer holding 1 entry -> all outputs 0 immediately (async), state IDLE; release, pc_count=0x0 -> imem_req=1, imem_addr=0x0, pc_advance=1 on first edge.
- Single fetch: pc_count=0x10, imem_rvalid 2 cycles after req with rdata=0x00A00093, id_ready=1 -> if_valid=1 with if_pc=0x10, if_instr=0x00A00093 the cycle after rvalid; popped next edge.
- Fill/stall: id_ready=0, 1-cycle memory latency, pc 0x0,0x4 -> exactly DEPTH=2 requests, then imem_req stays 0; raise id_ready -> heads 0x0 then 0x4 in order, fetch of 0x8 resumes.
- Redirect in WAIT: request to 0x20 outstanding, pulse redirect, rvalid arrives next cycle with 0xDEADBEEF -> never appears on if_instr; if_valid=0; next request uses new pc_count=0x100.
- Simultaneous push/pop: count=1, id_ready=1 and imem_rvalid same cycle -> count stays 1, if_pc moves to the newly fetched PC.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=16): never assert rvalid -> fetch_err=1 on the 16th WAIT cycle, FSM IDLE, next request issues; fetch_err stays 1 until reset.
